// File: rtl/div_seq_if.sv
// Issue/writeback bundle between ex/ctrl and the divide sequencer.
// master = issuing side (ex/ctrl), slave = div_seq.
interface div_seq_if #(
  parameter int DATA_W = 32
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] dividend_i;
  logic [DATA_W-1:0] divisor_i;
  logic [4:0]        rd_addr_i;
  logic              flush_i;
  logic              busy_o;
  logic              hold_flag_o;
  logic              done_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [4:0]        rd_addr_o;
  logic              rd_wen_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    input  busy_o, hold_flag_o, done_o, rd_data_o, rd_addr_o, rd_wen_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, rd_addr_i, flush_i,
    output busy_o, hold_flag_o, done_o, rd_data_o, rd_addr_o, rd_wen_o
  );
endinterface

// File: rtl/div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring divide, one step per cycle.
// Optional DIV_SEQ_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
//
//   state  | meaning
//   IDLE   | waiting for start_i; special cases resolve straight to DONE
//   CALC   | one restoring step per cycle, counter 0..DATA_W-1
//   DONE   | one-cycle register-file write of the fixed-up result
module div_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic              quot_neg_q, quot_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              special_q, special_d;

  logic              signed_op, a_neg, b_neg, accept;
  logic              div_zero, overflow, early;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   rem_sh, trial;
  logic [DATA_W-1:0] q_fix, r_fix, result;

  assign signed_op = ~bus.op_i[0];
  assign a_neg     = signed_op & bus.dividend_i[DATA_W-1];
  assign b_neg     = signed_op & bus.divisor_i[DATA_W-1];
  assign a_mag     = a_neg ? -bus.dividend_i : bus.dividend_i;
  assign b_mag     = b_neg ? -bus.divisor_i  : bus.divisor_i;
  assign accept    = bus.start_i & ~bus.flush_i;
  assign div_zero  = (bus.divisor_i == '0);
  assign overflow  = signed_op && (bus.dividend_i == INT_MIN) && (bus.divisor_i == '1);

`ifdef DIV_SEQ_EARLY_OUT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // rem_q < dvs_q holds throughout, so bit DATA_W of the trial is the borrow.
  assign rem_sh = {rem_q, quo_q[DATA_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      op_q       <= '0;
      rd_addr_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      op_q       <= op_d;
      rd_addr_q  <= rd_addr_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      special_q  <= special_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    op_d       = op_q;
    rd_addr_d  = rd_addr_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    special_d  = special_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = bus.op_i;
          rd_addr_d  = bus.rd_addr_i;
          quot_neg_d = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          dvs_d      = b_mag;
          cnt_d      = '0;
          special_d  = 1'b0;
          if (div_zero) begin
            quo_d     = '1;
            rem_d     = bus.dividend_i;
            special_d = 1'b1;
            state_d   = S_DONE;
          end else if (overflow) begin
            quo_d     = INT_MIN;
            rem_d     = '0;
            special_d = 1'b1;
            state_d   = S_DONE;
          end else if (early) begin
            quo_d   = '0;
            rem_d   = a_mag;
            state_d = S_DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
          rem_d = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Special-case results are already in final form and skip the sign fixup.
  assign q_fix  = quot_neg_q ? -quo_q : quo_q;
  assign r_fix  = rem_neg_q  ? -rem_q : rem_q;
  assign result = special_q ? (op_q[1] ? rem_q : quo_q)
                            : (op_q[1] ? r_fix : q_fix);

  assign bus.busy_o      = (state_q == S_CALC) || (state_q == S_DONE);
  assign bus.hold_flag_o = ((state_q == S_IDLE) && accept) || (state_q == S_CALC);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.rd_wen_o    = (state_q == S_DONE);
  assign bus.rd_data_o   = (state_q == S_DONE) ? result : '0;
  assign bus.rd_addr_o   = rd_addr_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed plan cases plus random ops
// against an arithmetic reference model of RV32M divide semantics.
module tb_div_seq;

  bit   clk;
  logic rst;
  int   vectors;
  int   miscompares;

  div_seq_if #(.DATA_W(32)) bus ();

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    sa = op[0] ? longint'(a) : longint'($signed(a));
    sb = op[0] ? longint'(b) : longint'($signed(b));
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
`ifdef DIV_SEQ_EARLY_OUT_EN
    if (sa < sb) return 1;
`endif
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered mid-cycle (the issue cycle); leaves mid-cycle of the last observed cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int noise_lo, input int noise_hi,
                        input int flush_at);
    logic [31:0] exp_data;
    int exp_lat, last, done_cnt, hold_cnt;
    bit cancel;
    exp_data = ref_result(op, a, b);
    exp_lat  = ref_latency(op, a, b);
    cancel   = (flush_at > 0) && (flush_at < exp_lat);
    last     = cancel ? flush_at + 2 : exp_lat + 1;
    done_cnt = 0;
    hold_cnt = 0;
    bus.start_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.rd_addr_i  = rd;
    #1;
    check("hold_issue", 32'(bus.hold_flag_o), 32'd1);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c >= noise_lo && c <= noise_hi) begin
        bus.start_i    = 1'b1;
        bus.op_i       = 2'($urandom_range(0, 3));
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
        bus.rd_addr_i  = 5'($urandom);
      end else begin
        bus.start_i = 1'b0;
      end
      bus.flush_i = (c == flush_at);
      #1;
      if (bus.done_o) done_cnt++;
      if (bus.hold_flag_o) hold_cnt++;
      if (!cancel && c == exp_lat) begin
        check("done_cycle", 32'(bus.done_o), 32'd1);
        check("rd_wen", 32'(bus.rd_wen_o), 32'd1);
        check("rd_data", bus.rd_data_o, exp_data);
        check("rd_addr", 32'(bus.rd_addr_o), 32'(rd));
      end
      if (cancel && c == flush_at + 1) check("busy_after_flush", 32'(bus.busy_o), 32'd0);
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("done_pulses", 32'(done_cnt), cancel ? 32'd0 : 32'd1);
    check("hold_cycles", 32'(hold_cnt), cancel ? 32'(flush_at) : 32'(exp_lat - 1));
  endtask

  initial begin
    int done_seen;
    logic [31:0] a, b;
    vectors     = 0;
    miscompares = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.rd_addr_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_wen", 32'(bus.rd_wen_o), 32'd0);
    check("rst_data", bus.rd_data_o, 32'd0);
    check("rst_addr", 32'(bus.rd_addr_o), 32'd0);
    check("rst_hold", 32'(bus.hold_flag_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(2'b01, 32'd100, 32'd7, 5'd5, 0, -1, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, -1, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, -1, 0);
    run_op(2'b00, 32'd123, 32'd0, 5'd8, 0, -1, 0);
    run_op(2'b11, 32'd123, 32'd0, 5'd9, 0, -1, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, -1, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, -1, 0);
    run_op(2'b01, 32'd3, 32'd10, 5'd12, 0, -1, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd13, 0, -1, 0);

    run_op(2'b01, 32'd1000, 32'd3, 5'd4, 0, -1, 10);
    run_op(2'b01, 32'd1000, 32'd3, 5'd4, 0, -1, 0);
    run_op(2'b01, 32'd100, 32'd7, 5'd5, 5, 20, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd14, 0, -1, 33);

    // start together with flush in IDLE must be ignored
    bus.start_i    = 1'b1;
    bus.flush_i    = 1'b1;
    bus.op_i       = 2'b01;
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd5;
    #1;
    check("hold_start_flush", 32'(bus.hold_flag_o), 32'd0);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    check("busy_start_flush", 32'(bus.busy_o), 32'd0);

    // reset in cycle 15 of an op abandons it
    bus.start_i    = 1'b1;
    bus.op_i       = 2'b01;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd7;
    bus.rd_addr_i  = 5'd9;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      rst = (c == 15);
    end
    #1;
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    check("mid_rst_wen", 32'(bus.rd_wen_o), 32'd0);
    check("mid_rst_data", bus.rd_data_o, 32'd0);
    check("mid_rst_addr", 32'(bus.rd_addr_o), 32'd0);
    check("mid_rst_hold", 32'(bus.hold_flag_o), 32'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #2;
      if (bus.done_o) done_seen++;
    end
    check("mid_rst_no_write", 32'(done_seen), 32'd0);

    for (int n = 0; n < 48; n++) begin
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
        3: begin a = 32'($urandom_range(0, 200)); b = $urandom; end
        4: begin a = $urandom; b = -32'($urandom_range(1, 9)); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      run_op(2'($urandom_range(0, 3)), a, b, 5'($urandom), 0, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
